gpr_wb_arbiter: RTL

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_wb_arbiter_pkg.sv | 32 +++
 rtl/gpr_wb_slot.sv | 59 +++++
 rtl/gpr_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_pkg
// Shared types and constants for the GPR writeback arbiter.
//   - gpr_wb_entry_t : one holding entry {valid, waddr, wdata}
//   - req_id_e       : requester identifier (REQ_EXU, REQ_LSU)
//   - GPR_X0         : index of the hard-wired zero register
// The entry struct is sized for the architectural register file
// (GPR_ADDR_W x GPR_DATA_W); module width parameters must not exceed these.
// -----------------------------------------------------------------------------
package gpr_wb_arbiter_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 64;
    localparam int GPR_X0     = 0;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  valid;
        logic [GPR_ADDR_W-1:0] waddr;
        logic [GPR_DATA_W-1:0] wdata;
    } gpr_wb_entry_t;

    // The requester that did not win a contended grant.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_EXU) ? REQ_LSU : REQ_EXU;
    endfunction

endpackage

// File: rtl/gpr_wb_slot.sv
// -----------------------------------------------------------------------------
// gpr_wb_slot
// One writeback holding entry: captures a request, clears when its write is
// granted, and compares its target index against a hazard query.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : handshake completed this cycle (capture request)
//   i_clear       : entry granted to the register file this cycle
//   i_waddr/wdata : request payload
//   i_q_addr      : hazard query index
//   o_valid/o_waddr/o_wdata : held entry contents
//   o_q_match     : held entry targets i_q_addr (never for x0)
// -----------------------------------------------------------------------------
module gpr_wb_slot
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int DATA_WIDTH = GPR_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_q_addr,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_q_match
);

    gpr_wb_entry_t r_entry;
    logic          w_is_x0;

    assign w_is_x0 = (i_waddr == ADDR_WIDTH'(GPR_X0));

    // A load can coincide with a clear (drain-and-refill); the load wins.
    // Writes to x0 complete the handshake but leave the entry empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry <= '0;
        end else if (i_load) begin
            r_entry.valid <= !w_is_x0;
            r_entry.waddr <= GPR_ADDR_W'(i_waddr);
            r_entry.wdata <= GPR_DATA_W'(i_wdata);
        end else if (i_clear) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign o_valid   = r_entry.valid;
    assign o_waddr   = ADDR_WIDTH'(r_entry.waddr);
    assign o_wdata   = DATA_WIDTH'(r_entry.wdata);
    assign o_q_match = r_entry.valid
                    && (i_q_addr != ADDR_WIDTH'(GPR_X0))
                    && (ADDR_WIDTH'(r_entry.waddr) == i_q_addr);

endmodule

// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
// Merges EXU and LSU writeback requests onto a single register-file write port.
// Each requester owns one holding entry; one entry is granted per cycle.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   exu_valid/ready/waddr/wdata       : EXU writeback request (valid/ready)
//   lsu_valid/ready/waddr/wdata       : LSU writeback request (valid/ready)
//   rf_wen/rf_waddr/rf_wdata          : register-file write port
//   q_addr / q_hit                    : hazard query against held entries
//   grant_lsu                         : current rf write comes from LSU entry
// Configuration macro:
//   GPR_WB_ARB_RR_EN : when defined, different-index conflicts are resolved
//                      round-robin; otherwise the LSU always wins them.
// Equal-index conflicts always go to the older entry so the register ends up
// with the later program-order value.
// -----------------------------------------------------------------------------
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] q_addr,
    output logic                  q_hit,
    output logic                  grant_lsu
);

    // Index 0 = EXU, index 1 = LSU throughout.
    logic [1:0]            w_req_valid;
    logic [ADDR_WIDTH-1:0] w_req_waddr [2];
    logic [DATA_WIDTH-1:0] w_req_wdata [2];
    logic [1:0]            w_ready;
    logic [1:0]            w_fire;
    logic [1:0]            w_cap;
    logic [1:0]            w_grant;
    logic [1:0]            w_held;
    logic [1:0]            w_q_match;
    logic [ADDR_WIDTH-1:0] w_held_waddr [2];
    logic [DATA_WIDTH-1:0] w_held_wdata [2];

    logic                  w_any_grant;
    req_id_e               w_grant_id;
    req_id_e               w_diff_pick;
    req_id_e               r_older;

    assign w_req_valid    = {lsu_valid, exu_valid};
    assign w_req_waddr[0] = exu_waddr;
    assign w_req_waddr[1] = lsu_waddr;
    assign w_req_wdata[0] = exu_wdata;
    assign w_req_wdata[1] = lsu_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            // Ready when empty or being drained this cycle; never in reset.
            assign w_ready[gi] = !rst && (!w_held[gi] || w_grant[gi]);
            assign w_fire[gi]  = w_req_valid[gi] && w_ready[gi];
            // Only non-x0 transfers create a held entry.
            assign w_cap[gi]   = w_fire[gi] && (w_req_waddr[gi] != ADDR_WIDTH'(GPR_X0));

            gpr_wb_slot #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .i_load    (w_fire[gi]),
                .i_clear   (w_grant[gi]),
                .i_waddr   (w_req_waddr[gi]),
                .i_wdata   (w_req_wdata[gi]),
                .i_q_addr  (q_addr),
                .o_valid   (w_held[gi]),
                .o_waddr   (w_held_waddr[gi]),
                .o_wdata   (w_held_wdata[gi]),
                .o_q_match (w_q_match[gi])
            );
        end
    endgenerate

    // Grant selection over held entries only, so ready never depends on valid.
    always_comb begin
        w_any_grant = 1'b0;
        w_grant_id  = REQ_EXU;
        if (!rst) begin
            if (w_held[0] && w_held[1]) begin
                w_any_grant = 1'b1;
                w_grant_id  = (w_held_waddr[0] == w_held_waddr[1]) ? r_older : w_diff_pick;
            end else if (w_held[1]) begin
                w_any_grant = 1'b1;
                w_grant_id  = REQ_LSU;
            end else if (w_held[0]) begin
                w_any_grant = 1'b1;
                w_grant_id  = REQ_EXU;
            end
        end
    end

    assign w_grant[0] = w_any_grant && (w_grant_id == REQ_EXU);
    assign w_grant[1] = w_any_grant && (w_grant_id == REQ_LSU);

    // Age tracking: a new LSU capture is never older than a held EXU entry
    // (same-edge captures count EXU first); a lone new EXU capture is younger
    // than whatever the LSU already holds. When the other entry is empty the
    // flag value is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_older <= REQ_EXU;
        end else if (w_cap[1]) begin
            r_older <= REQ_EXU;
        end else if (w_cap[0]) begin
            r_older <= REQ_LSU;
        end
    end

`ifdef GPR_WB_ARB_RR_EN
    req_id_e r_rr_ptr;
    logic    w_contended;

    assign w_contended = w_held[0] && w_held[1] && !rst;

    // After any contended grant the pointer moves to the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= REQ_LSU;
        end else if (w_contended) begin
            r_rr_ptr <= other_req(w_grant_id);
        end
    end

    assign w_diff_pick = r_rr_ptr;
`else
    assign w_diff_pick = REQ_LSU;
`endif

    assign exu_ready = w_ready[0];
    assign lsu_ready = w_ready[1];
    assign rf_wen    = w_any_grant;
    assign grant_lsu = w_grant[1];
    assign rf_waddr  = w_any_grant ? w_held_waddr[w_grant_id] : '0;
    assign rf_wdata  = w_any_grant ? w_held_wdata[w_grant_id] : '0;
    assign q_hit     = !rst && (|w_q_match);

endmodule
